// File: rtl/vga_stream_gen.sv
// Head of the 26-bit RGB pixel stream: raster counters plus one registered stream word per px_clk.
// Optional macro VGA_STREAM_TEST_PATTERN_EN replaces bg_color with 64-pixel colour bars.
module vga_stream_gen #(
  parameter int       H_ACTIVE = 640,
  parameter int       H_FP     = 16,
  parameter int       H_SYNC   = 96,
  parameter int       H_BP     = 48,
  parameter int       V_ACTIVE = 480,
  parameter int       V_FP     = 10,
  parameter int       V_SYNC   = 2,
  parameter int       V_BP     = 33,
  parameter bit       SYNC_POL = 1'b0,
  parameter bit [2:0] bg_color = 3'b000
) (
  input  logic        px_clk,
  input  logic        reset,
  output logic [25:0] strRGB_o,
  output logic        frame_start,
  output logic        line_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit bounds so a total of exactly 1024 still compares correctly
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  logic [9:0]  h_cnt, v_cnt;
  logic [10:0] h_ext, v_ext;
  logic        act, hs, vs;
  logic [2:0]  rgb;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  always_comb begin
    act = (h_ext < H_ACT) && (v_ext < V_ACT);
    hs  = (h_ext >= HS_BEG && h_ext < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs  = (v_ext >= VS_BEG && v_ext < VS_END) ? SYNC_POL : ~SYNC_POL;
    rgb = 3'b000;
    if (act) begin
`ifdef VGA_STREAM_TEST_PATTERN_EN
      rgb = h_cnt[8:6];
`else
      rgb = bg_color;
`endif
    end
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      strRGB_o    <= {3'b000, 10'd0, 10'd0, ~SYNC_POL, ~SYNC_POL, 1'b0};
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
      strRGB_o    <= {rgb, h_cnt, v_cnt, hs, vs, act};
      frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      line_start  <= (h_cnt == 10'd0);
    end
  end
endmodule

// File: tb/tb_vga_stream_gen.sv
// Directed bench: full-size instance for reset/line/colour checks, a shrunken raster
// (24x12 totals) for frame, wrap and mid-frame reset checks within a short run.
module tb_vga_stream_gen;
  logic        px_clk = 1'b0;
  logic        rst_a, rst_b;
  logic [25:0] s_a, s_b;
  logic        fs_a, ls_a, fs_b, ls_b;
  int          pass_cnt = 0;
  int          total    = 0;

  always #5 px_clk = ~px_clk;

  vga_stream_gen #(.bg_color(3'b101)) dut (
    .px_clk(px_clk), .reset(rst_a), .strRGB_o(s_a), .frame_start(fs_a), .line_start(ls_a));

  // small raster: H 16+2+4+2=24, V 8+1+2+1=12, frame 288 words, vsync low on Y 9..10
  vga_stream_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
                   .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_s (
    .px_clk(px_clk), .reset(rst_b), .strRGB_o(s_b), .frame_start(fs_b), .line_start(ls_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge px_clk);
      chk("reset_word", 32'(s_a), 32'h6);
      chk("reset_fs_ls", {30'd0, fs_a, ls_a}, 32'd0);
    end
    chk("reset_word_small", 32'(s_b), 32'h6);
    rst_a = 1'b0;
    @(negedge px_clk);
    chk("release_xy", {12'd0, s_a[22:13], s_a[12:3]}, 32'd0);
    chk("release_active", 32'(s_a[0]), 32'd1);
    chk("release_fs", 32'(fs_a), 32'd1);
    chk("release_ls", 32'(ls_a), 32'd1);
  endtask

  task automatic test_line;
    int n_act = 0, n_hs = 0, bad = 0, bad_rgb = 0;
    logic [2:0] rgb0 = '0, rgb64 = '0, rgb448 = '0, rgb700 = '1;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) @(negedge px_clk);
      if (s_a[22:13] != 10'(i) || s_a[12:3] != 10'd0) bad++;
      if (s_a[0] != (i < 640)) bad++;
      if (s_a[2] != !(i >= 656 && i < 752)) bad++;
      if (ls_a != (i == 0)) bad++;
      if (s_a[0]) n_act++;
      if (!s_a[2]) n_hs++;
`ifndef VGA_STREAM_TEST_PATTERN_EN
      if (s_a[0] && s_a[25:23] != 3'b101) bad_rgb++;
`endif
      if (!s_a[0] && s_a[25:23] != 3'b000) bad_rgb++;
      if (i == 0)   rgb0   = s_a[25:23];
      if (i == 64)  rgb64  = s_a[25:23];
      if (i == 448) rgb448 = s_a[25:23];
      if (i == 700) rgb700 = s_a[25:23];
    end
    chk("line_active_count", n_act, 640);
    chk("line_hsync_count", n_hs, 96);
    chk("line_positions", bad, 0);
    chk("line_rgb", bad_rgb, 0);
    chk("rgb_x700", 32'(rgb700), 32'd0);
`ifdef VGA_STREAM_TEST_PATTERN_EN
    chk("pattern_x0", 32'(rgb0), 32'd0);
    chk("pattern_x64", 32'(rgb64), 32'd1);
    chk("pattern_x448", 32'(rgb448), 32'd7);
`else
    chk("bg_x0", 32'(rgb0), 32'd5);
    chk("bg_x448", 32'(rgb448), 32'd5);
`endif
    @(negedge px_clk);
    chk("next_line_ls", 32'(ls_a), 32'd1);
    chk("next_line_xy", {12'd0, s_a[22:13], s_a[12:3]}, {22'd0, 10'd1});
    chk("next_line_fs", 32'(fs_a), 32'd0);
  endtask

  task automatic test_frame_and_wrap;
    int fs_idx[$];
    int bad_vs = 0, n_vs = 0, act_hi = 0, y_over = 0, wraps = 0, wrap_bad = 0;
    logic prev_end = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i <= 576; i++) begin
      @(negedge px_clk);
      if (fs_b) fs_idx.push_back(i);
      if (s_b[1] != !(s_b[12:3] == 10'd9 || s_b[12:3] == 10'd10)) bad_vs++;
      if (!s_b[1]) n_vs++;
      if (s_b[0] && s_b[12:3] >= 10'd8) act_hi++;
      if (s_b[12:3] >= 10'd12) y_over++;
      if (prev_end) begin
        wraps++;
        if (!(fs_b && ls_b && s_b[22:3] == 20'd0)) wrap_bad++;
      end
      prev_end = (s_b[22:13] == 10'd23 && s_b[12:3] == 10'd11);
    end
    chk("frame_fs_count", fs_idx.size(), 3);
    if (fs_idx.size() == 3) begin
      chk("frame_gap1", fs_idx[1] - fs_idx[0], 288);
      chk("frame_gap2", fs_idx[2] - fs_idx[1], 288);
    end
    chk("frame_vsync_pos", bad_vs, 0);
    chk("frame_vsync_count", n_vs, 96);
    chk("frame_active_y", act_hi, 0);
    chk("frame_y_range", y_over, 0);
    chk("wrap_seen", wraps, 2);
    chk("wrap_word", wrap_bad, 0);
  endtask

  task automatic test_mid_reset;
    int budget = 400;
    while (budget > 0 && !(s_b[22:13] == 10'd10 && s_b[12:3] == 10'd5)) begin
      @(negedge px_clk);
      budget--;
    end
    chk("midreset_reached", 32'(budget > 0), 32'd1);
    rst_b = 1'b1;
    @(negedge px_clk);
    chk("midreset_word", 32'(s_b), 32'h6);
    chk("midreset_fs_ls", {30'd0, fs_b, ls_b}, 32'd0);
    rst_b = 1'b0;
    @(negedge px_clk);
    chk("midreset_after_xy", 32'(s_b[22:3]), 32'd0);
    chk("midreset_after_fs", 32'(fs_b), 32'd1);
    chk("midreset_after_act", 32'(s_b[0]), 32'd1);
  endtask

  initial begin
    test_reset;
    test_line;
    test_frame_and_wrap;
    test_mid_reset;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
